// File: rtl/neuron_spike_scheduler_pkg.sv
// rtl/neuron_spike_scheduler_pkg.sv - shared sizes, spike-time type and scheduler state encoding
// Values mirror the num_spikes / time_period defines used by the neuron.
package neuron_pkg;
  localparam int NUM_SPIKES  = 8;
  localparam int TIME_PERIOD = 16;
  localparam int TW          = $clog2(TIME_PERIOD) + 1;
  localparam int LW          = (NUM_SPIKES > 1) ? $clog2(NUM_SPIKES) : 1;

  typedef logic [TW-1:0] spike_time_t;

  // Any time at or beyond the window length means the input never spikes.
  localparam spike_time_t NO_SPIKE  = spike_time_t'(TIME_PERIOD);
  localparam spike_time_t LAST_TICK = spike_time_t'(TIME_PERIOD - 1);

  typedef enum logic [1:0] {LOAD, RUN, DONE} sched_state_t;
endpackage

// File: rtl/neuron_spike_scheduler_if.sv
// rtl/neuron_spike_scheduler_if.sv - spike-time load and result handshakes of the scheduler
// master = spike-time source / result consumer side, slave = scheduler side.
interface neuron_spike_scheduler_if;
  import neuron_pkg::*;

  logic        in_valid;
  logic        in_ready;
  spike_time_t in_time;
  logic        out_valid;
  logic        out_ready;
  logic        out_fired;
  spike_time_t out_time;

  modport master (
    output in_valid, in_time, out_ready,
    input  in_ready, out_valid, out_fired, out_time
  );

  modport slave (
    input  in_valid, in_time, out_ready,
    output in_ready, out_valid, out_fired, out_time
  );
endinterface

// File: rtl/neuron_spike_scheduler_spike_time_decoder.sv
// rtl/neuron_spike_scheduler_spike_time_decoder.sv - stored spike times plus tick to spike vector
// NEURON_STEP_HOLD_EN selects step coding (high from spike time to window end) instead of pulses.
module spike_time_decoder
  import neuron_pkg::*;
(
  input  logic                  run,
  input  spike_time_t           tick,
  input  spike_time_t           times [NUM_SPIKES],
  output logic [NUM_SPIKES-1:0] spikes
);

  always_comb begin
    spikes = '0;
    for (int i = 0; i < NUM_SPIKES; i++) begin
`ifdef NEURON_STEP_HOLD_EN
      spikes[i] = run && (times[i] <= tick) && (times[i] < NO_SPIKE);
`else
      spikes[i] = run && (times[i] == tick);
`endif
    end
  end

endmodule

// File: rtl/neuron_spike_scheduler.sv
// rtl/neuron_spike_scheduler.sv - loads a spike-time volley, replays it over one window, reports first fire tick
// Spike coding follows NEURON_STEP_HOLD_EN inside spike_time_decoder.
module neuron_spike_scheduler
  import neuron_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_l,
  neuron_spike_scheduler_if.slave bus,
  output logic [NUM_SPIKES-1:0]   spikes_in,
  input  logic                    spikes_out,
  output logic                    busy
);

  sched_state_t  state_q, state_d;
  logic [LW-1:0] load_cnt_q;
  spike_time_t   tick_q;
  spike_time_t   ftime_q;
  spike_time_t   times_q [NUM_SPIKES];
  logic          fired_q;
  logic          load_beat, last_beat, last_tick, run;

  assign load_beat = (state_q == LOAD) && bus.in_valid;
  assign last_beat = load_beat && (load_cnt_q == LW'(NUM_SPIKES - 1));
  assign last_tick = (tick_q == LAST_TICK);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state_q <= LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (last_beat)     state_d = RUN;
      RUN:     if (last_tick)     state_d = DONE;
      DONE:    if (bus.out_ready) state_d = LOAD;
      default:                    state_d = LOAD;
    endcase
  end

  // Result outputs read as reset values outside DONE so a stale capture never leaks.
  always_comb begin
    run           = (state_q == RUN);
    busy          = (state_q != LOAD);
    bus.in_ready  = (state_q == LOAD);
    bus.out_valid = (state_q == DONE);
    bus.out_fired = (state_q == DONE) && fired_q;
    bus.out_time  = ((state_q == DONE) && fired_q) ? ftime_q : NO_SPIKE;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      load_cnt_q <= '0;
      tick_q     <= '0;
      fired_q    <= 1'b0;
      ftime_q    <= NO_SPIKE;
      for (int i = 0; i < NUM_SPIKES; i++) times_q[i] <= NO_SPIKE;
    end else begin
      if (load_beat) begin
        times_q[load_cnt_q] <= bus.in_time;
        load_cnt_q          <= last_beat ? '0 : load_cnt_q + 1'b1;
        if (last_beat) begin
          tick_q  <= '0;
          fired_q <= 1'b0;
        end
      end
      if (run) begin
        tick_q <= last_tick ? '0 : tick_q + 1'b1;
        // spikes_out is combinational from spikes_in, so it reflects the current tick.
        if (spikes_out && !fired_q) begin
          fired_q <= 1'b1;
          ftime_q <= tick_q;
        end
      end
    end
  end

  spike_time_decoder u_decoder (
    .run    (run),
    .tick   (tick_q),
    .times  (times_q),
    .spikes (spikes_in)
  );

endmodule

// File: tb/tb_neuron_spike_scheduler.sv
// tb/tb_neuron_spike_scheduler.sv - directed volleys against a window-level model of the scheduler
// Neuron stub fires when at least two inputs spike together; honours NEURON_STEP_HOLD_EN.
module tb_neuron_spike_scheduler;
  import neuron_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_l = 1'b0;
  logic [NUM_SPIKES-1:0] spikes_in;
  logic                  spikes_out;
  logic                  busy;

  neuron_spike_scheduler_if bus();

  neuron_spike_scheduler dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .bus        (bus),
    .spikes_in  (spikes_in),
    .spikes_out (spikes_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  assign spikes_out = ($countones(spikes_in) >= 2);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Window-level model: phase 0 collecting, 1 replaying, 2 reporting.
  int m_phase = 0;
  int m_cnt   = 0;
  int m_tick  = 0;
  int m_ftime = TIME_PERIOD;
  int m_times [NUM_SPIKES];

  function automatic logic [NUM_SPIKES-1:0] exp_vec(input int t);
    logic [NUM_SPIKES-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_SPIKES; i++) begin
`ifdef NEURON_STEP_HOLD_EN
      v[i] = (m_times[i] <= t) && (m_times[i] < TIME_PERIOD);
`else
      v[i] = (m_times[i] == t);
`endif
    end
    return v;
  endfunction

  function automatic int first_fire();
    for (int t = 0; t < TIME_PERIOD; t++)
      if ($countones(exp_vec(t)) >= 2) return t;
    return TIME_PERIOD;
  endfunction

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      m_phase = 0;
      m_cnt   = 0;
      m_tick  = 0;
      m_ftime = TIME_PERIOD;
    end else begin
      case (m_phase)
        0: if (bus.in_valid) begin
             m_times[m_cnt] = int'(bus.in_time);
             m_cnt++;
             if (m_cnt == NUM_SPIKES) begin
               m_cnt   = 0;
               m_tick  = 0;
               m_phase = 1;
             end
           end
        1: if (m_tick == TIME_PERIOD - 1) begin
             m_ftime = first_fire();
             m_phase = 2;
           end else begin
             m_tick++;
           end
        default: if (bus.out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [NUM_SPIKES-1:0] ev;
    ev = (m_phase == 1) ? exp_vec(m_tick) : '0;
    chk("cyc_spikes_in", int'(spikes_in), int'(ev));
    chk("cyc_in_ready", int'(bus.in_ready), int'(m_phase == 0));
    chk("cyc_out_valid", int'(bus.out_valid), int'(m_phase == 2));
    chk("cyc_busy", int'(busy), int'(m_phase != 0));
    chk("cyc_out_fired", int'(bus.out_fired), int'(m_phase == 2 && m_ftime < TIME_PERIOD));
    chk("cyc_out_time", int'(bus.out_time), (m_phase == 2) ? m_ftime : TIME_PERIOD);
  end

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic load_beats(input int a0, input int a1, input int a2, input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_time  = spike_time_t'((i == 0) ? a0 : (i == 1) ? a1 : (i == 2) ? a2 : TIME_PERIOD);
      tick_clk();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_volley(input int a0, input int a1, input int a2,
                            output int lat, output int fired, output int ftime);
    int k;
    load_beats(a0, a1, a2, NUM_SPIKES);
    k = NUM_SPIKES;
    while (!bus.out_valid && k < 80) begin
      tick_clk();
      k++;
    end
    if (!bus.out_valid) chk("wait_out_valid_timeout", 0, 1);
    lat   = k;
    fired = int'(bus.out_fired);
    ftime = int'(bus.out_time);
  endtask

  task automatic accept();
    bus.out_ready = 1'b1;
    tick_clk();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int lat, f, t;
    bus.in_valid  = 1'b0;
    bus.in_time   = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < NUM_SPIKES; i++) m_times[i] = TIME_PERIOD;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_fired", int'(bus.out_fired), 0);
    chk("rst_out_time", int'(bus.out_time), 16);
    chk("rst_spikes_in", int'(spikes_in), 0);
    chk("rst_busy", int'(busy), 0);
    rst_l = 1'b1;
    tick_clk();

    run_volley(3, 3, 16, lat, f, t);
    chk("pair3_latency", lat, 24);
    chk("pair3_fired", f, 1);
    chk("pair3_time", t, 3);
    accept();

    run_volley(16, 16, 16, lat, f, t);
    chk("silent_fired", f, 0);
    chk("silent_time", t, 16);
    accept();

    run_volley(0, 0, 5, lat, f, t);
    chk("tick0_fired", f, 1);
    chk("tick0_time", t, 0);
    accept();

    run_volley(15, 15, 16, lat, f, t);
    chk("tick15_fired", f, 1);
    chk("tick15_time", t, 15);
    accept();

    run_volley(2, 6, 16, lat, f, t);
`ifdef NEURON_STEP_HOLD_EN
    chk("step_fired", f, 1);
    chk("step_time", t, 6);
`else
    chk("pulse_apart_fired", f, 0);
    chk("pulse_apart_time", t, 16);
`endif
    accept();

    run_volley(3, 3, 16, lat, f, t);
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'b1;
      bus.in_time  = spike_time_t'($urandom_range(0, 16));
      tick_clk();
      chk("hold_out_valid", int'(bus.out_valid), 1);
      chk("hold_out_time", int'(bus.out_time), 3);
      chk("hold_in_ready", int'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    accept();
    chk("after_accept_out_valid", int'(bus.out_valid), 0);

    load_beats(3, 3, 16, 3);
    rst_l = 1'b0;
    #1;
    chk("load_abort_busy", int'(busy), 0);
    tick_clk();
    rst_l = 1'b1;

    load_beats(0, 0, 5, NUM_SPIKES);
    repeat (7) tick_clk();
    rst_l = 1'b0;
    #1;
    chk("run_abort_spikes_in", int'(spikes_in), 0);
    chk("run_abort_out_valid", int'(bus.out_valid), 0);
    chk("run_abort_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    chk("run_abort_in_ready", int'(bus.in_ready), 1);

    run_volley(15, 15, 16, lat, f, t);
    chk("post_reset_latency", lat, 24);
    chk("post_reset_time", t, 15);
    accept();

    run_volley(3, 3, 16, lat, f, t);
    chk("final_time", t, 3);
    accept();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
